registro_sumador_multicanal: RTL

REGISTRO_SUMADOR_MULTICANAL -- requirements
Module: registro_sumador_multicanal

---
 rtl/registro_sumador_multicanal.sv | 109 ++++++++++
 1 files changed

// File: rtl/registro_sumador_multicanal.sv
// rtl/registro_sumador_multicanal.sv - multi-channel step adder with per-channel base/limit and wrap or saturate.
// Saturate mode is selected by defining REGISTRO_SUMADOR_SATURACION_EN; the default build wraps to base.
module registro_sumador_multicanal #(
  parameter int BITS_DATOS = 18,
  parameter int BITS_PASO  = 8,
  parameter int CANALES    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CANALES-1:0]              guardar,
  input  logic [CANALES-1:0]              sumar,
  input  logic [CANALES*BITS_DATOS-1:0]   base,
  input  logic [CANALES*BITS_DATOS-1:0]   limite,
  input  logic [CANALES*BITS_PASO-1:0]    paso,
  output logic [CANALES*BITS_DATOS-1:0]   resultado,
  output logic [CANALES-1:0]              activo,
  output logic [CANALES-1:0]              vuelta
);

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    CONTANDO = 2'd1,
    FIN      = 2'd2
  } estado_t;

  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    estado_t                 estado;
    estado_t                 estado_sig;
    logic [BITS_DATOS-1:0]   res_reg;
    logic [BITS_DATOS-1:0]   base_reg;
    logic [BITS_DATOS-1:0]   lim_reg;
    logic [BITS_PASO-1:0]    paso_reg;
    logic                    vuelta_reg;
    logic [BITS_DATOS:0]     siguiente;
    logic                    cruce;
    logic                    avanza;
    logic                    activo_c;

    // One extra bit keeps the carry, so an overflowing sum always compares above the limit.
    assign siguiente = {1'b0, res_reg} + {{(BITS_DATOS + 1 - BITS_PASO){1'b0}}, paso_reg};
    assign cruce     = siguiente > {1'b0, lim_reg};
    assign avanza    = sumar[i] && !guardar[i] && (estado == CONTANDO);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        estado <= INACTIVO;
      end else begin
        estado <= estado_sig;
      end
    end

    always_comb begin
      estado_sig = estado;
      if (guardar[i]) begin
        estado_sig = CONTANDO;
      end else begin
        case (estado)
          CONTANDO: begin
`ifdef REGISTRO_SUMADOR_SATURACION_EN
            if (sumar[i] && cruce) estado_sig = FIN;
`endif
          end
          INACTIVO: estado_sig = INACTIVO;
          FIN:      estado_sig = FIN;
          default:  estado_sig = INACTIVO;
        endcase
      end
    end

    always_comb begin
      activo_c = 1'b0;
      if (estado == CONTANDO) activo_c = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        res_reg    <= '0;
        base_reg   <= '0;
        lim_reg    <= '0;
        paso_reg   <= '0;
        vuelta_reg <= 1'b0;
      end else if (guardar[i]) begin
        res_reg    <= base[i*BITS_DATOS +: BITS_DATOS];
        base_reg   <= base[i*BITS_DATOS +: BITS_DATOS];
        lim_reg    <= limite[i*BITS_DATOS +: BITS_DATOS];
        paso_reg   <= paso[i*BITS_PASO +: BITS_PASO];
        vuelta_reg <= 1'b0;
      end else if (avanza) begin
        vuelta_reg <= cruce;
        if (!cruce) begin
          res_reg <= siguiente[BITS_DATOS-1:0];
        end else begin
`ifdef REGISTRO_SUMADOR_SATURACION_EN
          res_reg <= lim_reg;
`else
          res_reg <= base_reg;
`endif
        end
      end else begin
        vuelta_reg <= 1'b0;
      end
    end

    assign resultado[i*BITS_DATOS +: BITS_DATOS] = res_reg;
    assign activo[i] = activo_c;
    assign vuelta[i] = vuelta_reg;
  end

endmodule
